// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer with CDB writeback, operand query bypass
// and a one-cycle rollback flush after a mispredicted commit.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            dsp_valid,
    input  logic [4:0]      dsp_rd,
    input  logic [31:0]     dsp_pc,
    output logic            rob_full,
    output logic [ID_W-1:0] alloc_id,
    input  logic            cdb_valid,
    input  logic [ID_W-1:0] cdb_id,
    input  logic [31:0]     cdb_value,
    input  logic            cdb_mispredict,
    input  logic [31:0]     cdb_target_pc,
    input  logic [ID_W-1:0] query_id1,
    input  logic [ID_W-1:0] query_id2,
    output logic            query_ready1,
    output logic            query_ready2,
    output logic [31:0]     query_value1,
    output logic [31:0]     query_value2,
    output logic            rob_has_res,
    output logic [31:0]     result_from_rob,
    output logic [4:0]      regidx_from_rob,
    output logic [ID_W-1:0] regalias_from_rob,
    output logic            rollback_signal,
    output logic [31:0]     rollback_pc
);
    localparam int IW = $clog2(ROB_SIZE);
    localparam logic [ID_W-1:0] MAX_ID = ID_W'(ROB_SIZE);

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, next_state;

    logic [ROB_SIZE-1:0]        busy, ready, mispredict;
    logic [ROB_SIZE-1:0][4:0]   rd;
    logic [ROB_SIZE-1:0][31:0]  pc, value, target;
    logic [IW-1:0]              head, tail, cdb_slot;
    logic [IW:0]                count;
    logic                       cdb_hit, do_alloc, do_commit, unused_pc;

    // PC is retained per entry for debug visibility; nothing downstream consumes it yet
    assign unused_pc = ^pc;

    function automatic logic [32:0] lookup(input logic [ID_W-1:0] id);
        logic [IW-1:0] s = IW'(id - ID_W'(1));
        if (id == '0 || id > MAX_ID) return '0;
        if (cdb_valid && cdb_id == id) return {1'b1, cdb_value};
        return {ready[s], ready[s] ? value[s] : 32'h0};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else if (rdy) state <= next_state;
    end

    always_comb begin
        next_state = state == FLUSH ? RUN : (do_commit && mispredict[head]) ? FLUSH : RUN;
    end

    always_comb begin
        cdb_slot  = IW'(cdb_id - ID_W'(1));
        cdb_hit   = cdb_valid && cdb_id != '0 && cdb_id <= MAX_ID && busy[cdb_slot];
        rob_full  = count == (IW+1)'(ROB_SIZE) || state == FLUSH;
        alloc_id  = ID_W'(tail) + ID_W'(1);
        do_alloc  = dsp_valid && !rob_full;
        // commit looks only at the stored ready flag, so a CDB result commits one cycle later
        do_commit = state == RUN && busy[head] && ready[head];
        {query_ready1, query_value1} = lookup(query_id1);
        {query_ready2, query_value2} = lookup(query_id2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            mispredict        <= '0;
            rd                <= '0;
            pc                <= '0;
            value             <= '0;
            target            <= '0;
            rob_has_res       <= 1'b0;
            result_from_rob   <= '0;
            regidx_from_rob   <= '0;
            regalias_from_rob <= '0;
            rollback_signal   <= 1'b0;
            rollback_pc       <= '0;
        end else if (rdy) begin
            rob_has_res       <= do_commit;
            result_from_rob   <= do_commit ? value[head] : '0;
            regidx_from_rob   <= do_commit ? rd[head] : '0;
            regalias_from_rob <= do_commit ? ID_W'(head) + ID_W'(1) : '0;
            rollback_signal   <= state == FLUSH;
            rollback_pc       <= state == FLUSH ? rollback_pc :
                                 (do_commit && mispredict[head]) ? target[head] : '0;
            if (state == FLUSH) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_hit) begin
                    ready[cdb_slot]      <= 1'b1;
                    value[cdb_slot]      <= cdb_value;
                    mispredict[cdb_slot] <= cdb_mispredict;
                    target[cdb_slot]     <= cdb_target_pc;
                end
                if (do_alloc) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    mispredict[tail] <= 1'b0;
                    rd[tail]         <= dsp_rd;
                    pc[tail]         <= dsp_pc;
                    tail             <= tail + IW'(1);
                end
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + IW'(1);
                end
                count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors with hand-computed expectations for reorder_buffer.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy;
    logic        dsp_valid;
    logic [4:0]  dsp_rd;
    logic [31:0] dsp_pc;
    logic        rob_full;
    logic [4:0]  alloc_id;
    logic        cdb_valid;
    logic [4:0]  cdb_id;
    logic [31:0] cdb_value;
    logic        cdb_mispredict;
    logic [31:0] cdb_target_pc;
    logic [4:0]  query_id1, query_id2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        rob_has_res;
    logic [31:0] result_from_rob;
    logic [4:0]  regidx_from_rob;
    logic [4:0]  regalias_from_rob;
    logic        rollback_signal;
    logic [31:0] rollback_pc;
    int          vectors = 0;
    int          miscompares = 0;

    reorder_buffer #(.ROB_SIZE(16), .ID_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dsp_valid(dsp_valid), .dsp_rd(dsp_rd), .dsp_pc(dsp_pc),
        .rob_full(rob_full), .alloc_id(alloc_id),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .rob_has_res(rob_has_res), .result_from_rob(result_from_rob),
        .regidx_from_rob(regidx_from_rob), .regalias_from_rob(regalias_from_rob),
        .rollback_signal(rollback_signal), .rollback_pc(rollback_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; dsp_valid = 1'b0; dsp_rd = '0; dsp_pc = '0;
        cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target_pc = '0;
        query_id1 = '0; query_id2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic dispatch(input logic [4:0] r);
        dsp_valid = 1'b1; dsp_rd = r; dsp_pc = {27'h0, r} << 2;
        tick();
        dsp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] v, input logic m, input logic [31:0] t);
        cdb_valid = 1'b1; cdb_id = id; cdb_value = v; cdb_mispredict = m; cdb_target_pc = t;
        tick();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    endtask

    task automatic commit_expect(input string tag, input logic [31:0] v, input logic [4:0] r, input logic [4:0] a);
        check({tag, "_has_res"}, rob_has_res, 1);
        check({tag, "_value"}, result_from_rob, v);
        check({tag, "_regidx"}, regidx_from_rob, r);
        check({tag, "_alias"}, regalias_from_rob, a);
    endtask

    initial begin
        idle();
        #1 rst = 1'b0;
        #1;
        check("rst_full", rob_full, 0);
        check("rst_alloc_id", alloc_id, 1);
        check("rst_has_res", rob_has_res, 0);
        check("rst_rollback", rollback_signal, 0);
        @(negedge clk);
        rst = 1'b1;

        // basic dispatch / writeback / commit
        dsp_valid = 1'b1; dsp_rd = 5;
        #1 check("first_alloc_id", alloc_id, 1);
        tick();
        dsp_valid = 1'b0;
        check("alloc_id_after", alloc_id, 2);
        cdb(1, 32'hAB, 0, 0);
        check("no_commit_same_cycle", rob_has_res, 0);
        tick();
        commit_expect("basic", 32'hAB, 5, 1);
        tick();
        check("basic_pulse_end", rob_has_res, 0);
        check("basic_value_cleared", result_from_rob, 0);

        // fill, overflow, commit from full, wrap
        do_reset();
        for (int i = 0; i < 16; i++) dispatch(5'(i + 1));
        check("full_after_16", rob_full, 1);
        check("full_alloc_wrap", alloc_id, 1);
        dispatch(31);
        check("still_full", rob_full, 1);
        cdb(1, 32'h11, 0, 0);
        tick();
        commit_expect("from_full", 32'h11, 1, 1);
        check("full_dropped", rob_full, 0);
        check("wrap_alloc_id", alloc_id, 1);
        dispatch(9);
        check("refull", rob_full, 1);
        check("refull_alloc_id", alloc_id, 2);

        // out-of-order completion, in-order commit
        do_reset();
        dispatch(1);
        dispatch(2);
        cdb(2, 32'h22, 0, 0);
        tick();
        check("ooo_wait1", rob_has_res, 0);
        tick();
        check("ooo_wait2", rob_has_res, 0);
        cdb(1, 32'h11, 0, 0);
        check("ooo_wait3", rob_has_res, 0);
        tick();
        commit_expect("ooo_c1", 32'h11, 1, 1);
        tick();
        commit_expect("ooo_c2", 32'h22, 2, 2);
        tick();
        check("ooo_done", rob_has_res, 0);

        // mispredict -> rollback
        do_reset();
        dispatch(3);
        dispatch(4);
        cdb(1, 32'h77, 1, 32'h1000);
        tick();
        commit_expect("mp_commit", 32'h77, 3, 1);
        check("mp_commit_no_rb", rollback_signal, 0);
        check("mp_flush_full", rob_full, 1);
        cdb_valid = 1'b1; cdb_id = 2; cdb_value = 32'h66;
        tick();
        cdb_valid = 1'b0;
        check("rb_signal", rollback_signal, 1);
        check("rb_pc", rollback_pc, 32'h1000);
        check("rb_no_res", rob_has_res, 0);
        check("rb_not_full", rob_full, 0);
        check("rb_alloc_id", alloc_id, 1);
        query_id1 = 2;
        #1 check("rb_cdb_discarded", query_ready1, 0);
        tick();
        check("rb_pulse_end", rollback_signal, 0);
        check("rb_pc_cleared", rollback_pc, 0);
        check("rb_no_commit", rob_has_res, 0);
        query_id1 = 0;

        // reset in the middle of FLUSH
        do_reset();
        dispatch(6);
        cdb(1, 32'h5, 1, 32'h2000);
        tick();
        check("mid_flush_commit", rob_has_res, 1);
        rst = 1'b0;
        #1 check("mid_flush_reset_full", rob_full, 0);
        check("mid_flush_reset_res", rob_has_res, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_flush_no_rb", rollback_signal, 0);
        check("mid_flush_alloc", alloc_id, 1);

        // query with CDB bypass
        do_reset();
        dispatch(1);
        dispatch(2);
        dispatch(3);
        cdb_valid = 1'b1; cdb_id = 3; cdb_value = 32'h55;
        query_id1 = 3; query_id2 = 0;
        #1;
        check("bypass_ready", query_ready1, 1);
        check("bypass_value", query_value1, 32'h55);
        check("qid0_ready", query_ready2, 0);
        check("qid0_value", query_value2, 0);
        tick();
        cdb_valid = 1'b0;
        query_id2 = 2;
        #1;
        check("stored_ready", query_ready1, 1);
        check("stored_value", query_value1, 32'h55);
        check("pending_ready", query_ready2, 0);
        check("no_commit_head_pending", rob_has_res, 0);
        query_id1 = 0; query_id2 = 0;

        // freeze with rdy low
        do_reset();
        dispatch(7);
        cdb(1, 32'h99, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_no_commit", rob_has_res, 0);
            check("frozen_alloc_id", alloc_id, 2);
        end
        rdy = 1'b1;
        tick();
        commit_expect("after_rdy", 32'h99, 7, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
